// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a first-word-fall-through receive FIFO,
// with sticky overflow and framing-error flags for a status register.
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic [7:0]            data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  frame_err
);

  localparam int unsigned BIT_TIME = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF     = BIT_TIME / 2;
  localparam int unsigned CW       = $clog2(BIT_TIME);
  localparam int unsigned DEPTH    = 2 ** DEPTH_LOG2;
  localparam int unsigned PW       = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [1:0]            sync_q;
  logic                  rxs;
  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  push, ferr_set;

  logic [PW-1:0]         wptr_q, rptr_q;
  logic [7:0]            mem_q [DEPTH];
  logic                  ovf_q, ovf_d, ferr_q, ferr_d;
  logic                  pop, wr_en, ovf_set;

  assign rxs = sync_q[1];

  // Receiver state, counters and synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Frame decode; the stop bit is sampled once, at its midpoint
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CW'(BIT_TIME - 1)) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == CW'(BIT_TIME - 1)) begin
          cnt_d    = '0;
          state_d  = S_IDLE;
          push     = rxs;
          ferr_set = !rxs;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count   = wptr_q - rptr_q;
    empty   = (count == '0);
    full    = (count == PW'(DEPTH));
    pop     = rd && !empty;
    wr_en   = push && (!full || pop);
    ovf_set = push && full && !pop;
    data    = empty ? 8'h00 : mem_q[rptr_q[DEPTH_LOG2-1:0]];
    // A new error event wins over a simultaneous clear
    ovf_d   = (ovf_q && !clr_err) || ovf_set;
    ferr_d  = (ferr_q && !clr_err) || ferr_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + PW'(1);
      if (pop)   rptr_q <= rptr_q + PW'(1);
      ovf_q  <= ovf_d;
      ferr_q <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= shift_q;
  end

  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random frames, all outputs
// compared every cycle against a queue-based model of the receiver and FIFO.
module tb_uart_rx_fifo;

  localparam int unsigned BIT   = 10;
  localparam int unsigned HALF  = BIT / 2;
  localparam int unsigned DEPTH = 8;
  // Edges from the first edge that samples the start bit to the push edge:
  // 2 synchroniser edges, half a bit to mid-start, then 9 whole bits to mid-stop.
  localparam int unsigned LAT   = 2 + HALF + 9 * BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data;
  logic       empty, full, overflow, frame_err;
  logic [3:0] count;

  uart_rx_fifo #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000),
    .DEPTH_LOG2(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rd       (rd),
    .clr_err  (clr_err),
    .data     (data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          e;
    byte unsigned b;
    bit          ok;
  } ev_t;

  byte unsigned mq[$];
  ev_t          evq[$];
  bit           m_ovf = 1'b0;
  bit           m_fe  = 1'b0;
  int           cyc   = 0;

  // Behavioural model: a byte queue plus scheduled end-of-frame events
  always @(posedge clk) begin : model
    ev_t ev;
    bit  hit, do_pop, was_full;
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      evq.delete();
      m_ovf = 1'b0;
      m_fe  = 1'b0;
    end else begin
      hit = 1'b0;
      if (evq.size() > 0 && evq[0].e == cyc) begin
        ev  = evq.pop_front();
        hit = 1'b1;
      end
      do_pop   = rd && (mq.size() > 0);
      was_full = (mq.size() == DEPTH);
      if (clr_err) begin
        m_ovf = 1'b0;
        m_fe  = 1'b0;
      end
      if (do_pop) void'(mq.pop_front());
      if (hit) begin
        if (!ev.ok)                    m_fe  = 1'b1;
        else if (was_full && !do_pop)  m_ovf = 1'b1;
        else                           mq.push_back(ev.b);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(posedge clk) begin : compare
    logic [15:0] act, exp;
    #1;
    exp = {(mq.size() > 0) ? mq[0] : 8'h00, mq.size() == 0, mq.size() == DEPTH,
           4'(mq.size()), m_ovf, m_fe};
    act = {data, empty, full, count, overflow, frame_err};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cycle%0d {data,empty,full,count,ovf,ferr} got %h expected %h",
               cyc, act, exp);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1; rd = 1'b0; clr_err = 1'b0; rst = 1'b0;
    end
  endtask

  task automatic pulse_rd();
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
  endtask

  // Drive one 100-cycle frame; options: pin push latency, reset in a bit slot,
  // rd in the stop-sample cycle, random rd/clr_err traffic.
  task automatic send_frame(input byte unsigned b, input bit stop_ok, input int rst_slot,
                            input bit rd_at_stop, input bit rand_ctl, input bit pin);
    bit [9:0] fr;
    int       e;
    fr = {stop_ok, b, 1'b0};
    e  = 0;
    for (int k = 0; k < 10 * int'(BIT); k++) begin
      @(negedge clk);
      if (k == 0) begin
        e = cyc + 1 + int'(LAT);
        evq.push_back('{e, b, stop_ok});
      end
      if (pin && k == 97) chk("pre_push_empty", 8'(empty), 8'h01);
      if (pin && k == 98) begin
        chk("push_data", data, b);
        chk("push_count", 8'(count), 8'h01);
      end
      if (rst_slot >= 0 && k == rst_slot * int'(BIT) + 5) begin
        chk("rst_count", 8'(count), 8'h00);
        chk("rst_flags", {4'h0, empty, full, overflow, frame_err}, 8'h08);
        chk("rst_data", data, 8'h00);
      end
      rx      = fr[k / int'(BIT)];
      rd      = 1'b0;
      clr_err = 1'b0;
      rst     = (rst_slot >= 0) && (k == rst_slot * int'(BIT) + 3 || k == rst_slot * int'(BIT) + 4);
      if (rd_at_stop && cyc == e - 1) rd = 1'b1;
      if (rand_ctl) begin
        rd      = ($urandom_range(0, 39) == 0);
        clr_err = ($urandom_range(0, 199) == 0);
      end
    end
  endtask

  initial begin : stim
    byte unsigned last;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_count", 8'(count), 8'h00);
    chk("reset_flags", {4'h0, empty, full, overflow, frame_err}, 8'h08);
    chk("reset_data", data, 8'h00);
    idle(5);

    // Single byte, push latency and pop
    send_frame(8'hA5, 1'b1, -1, 1'b0, 1'b0, 1'b1);
    idle(5);
    chk("t1_data", data, 8'hA5);
    pulse_rd();
    chk("t1_empty_after_rd", 8'(empty), 8'h01);
    chk("t1_data_after_rd", data, 8'h00);
    idle(5);

    // Start-bit glitch
    repeat (3) begin @(negedge clk); rx = 1'b0; end
    idle(20);
    chk("t2_empty", 8'(empty), 8'h01);
    chk("t2_frame_err", 8'(frame_err), 8'h00);

    // Overflow on the ninth byte
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1, -1, 1'b0, 1'b0, 1'b0);
      idle(20);
    end
    chk("t3_count", 8'(count), 8'h08);
    chk("t3_full", 8'(full), 8'h01);
    chk("t3_overflow", 8'(overflow), 8'h01);
    for (int i = 1; i <= 8; i++) begin
      chk("t3_order", data, 8'(i));
      pulse_rd();
    end
    chk("t3_empty", 8'(empty), 8'h01);

    // Framing error and clear
    send_frame(8'h3C, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    idle(20);
    chk("t4_frame_err", 8'(frame_err), 8'h01);
    chk("t4_empty", 8'(empty), 8'h01);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    chk("t4_cleared", {6'h0, overflow, frame_err}, 8'h00);

    // Push and pop together while full
    for (int i = 0; i < 8; i++) begin
      send_frame(8'(8'h60 + i), 1'b1, -1, 1'b0, 1'b0, 1'b0);
      idle(20);
    end
    send_frame(8'h77, 1'b1, -1, 1'b1, 1'b0, 1'b0);
    idle(20);
    chk("t5_count", 8'(count), 8'h08);
    chk("t5_overflow", 8'(overflow), 8'h00);
    chk("t5_head", data, 8'h61);
    last = 8'h00;
    for (int i = 0; i < 8; i++) begin
      last = data;
      pulse_rd();
    end
    chk("t5_last", last, 8'h77);

    // Reset mid-frame with a byte held and an error pending
    send_frame(8'h11, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    idle(20);
    send_frame(8'h22, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    idle(20);
    send_frame(8'hF0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
    idle(20);
    chk("t6_no_push", 8'(empty), 8'h01);
    send_frame(8'h5A, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    idle(20);
    chk("t6_data", data, 8'h5A);
    pulse_rd();

    // Random frames with random pops and clears
    for (int i = 0; i < 30; i++) begin
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), -1, 1'b0, 1'b1, 1'b0);
      idle(20);
    end
    for (int i = 0; i < DEPTH + 2; i++) pulse_rd();
    chk("final_empty", 8'(empty), 8'h01);

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
